// File: rtl/gsim_band_matvec.sv
// Banded 16x16 GSIM forward product b = A*x: load 16 x words, compute one row per cycle by shift-add, stream 16 b words.
// Latency 16 cycles from last x to first b; input stalls (in_ready=0) through CALC/OUT; output has no backpressure.
module gsim_band_matvec #(
    parameter int VEC_LEN = 16,
    parameter int W_X     = 32,
    parameter int FRAC    = 16,
    parameter int W_B     = 38
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_en,
    input  logic [W_X-1:0] x_in,
    output logic           in_ready,
    output logic           out_valid,
    output logic [W_B-1:0] b_out,
    output logic [15:0]    b_int,
    output logic           b_sat,
    output logic           overrun
);
    localparam int CW  = $clog2(VEC_LEN);
    localparam int PAD = 3;
    localparam int XPW = VEC_LEN + 2 * PAD;
    localparam int IW  = $clog2(XPW);
    localparam logic [CW-1:0]       LAST  = CW'(VEC_LEN - 1);
    localparam logic signed [W_B:0] HALF  = (W_B + 1)'(1) << (FRAC - 1);
    localparam logic signed [W_B:0] T_MAX = (W_B + 1)'(32767);
    localparam logic signed [W_B:0] T_MIN = (W_B + 1)'(-32768);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [W_X-1:0]        x_q [VEC_LEN];
    logic [W_X-1:0]        x_d [VEC_LEN];
    logic signed [W_B-1:0] b_q [VEC_LEN];
    logic signed [W_B-1:0] b_d [VEC_LEN];
    logic                  overrun_q, overrun_d;

    logic signed [W_B-1:0] xp [XPW];
    logic [IW-1:0]         base;
    logic signed [W_B-1:0] xc, s1, s2, s3, row_val;
    logic signed [W_B:0]   rnd, t;

    // Zero padding on both ends makes out-of-range band taps read as 0 without wrap.
    always_comb begin
        for (int i = 0; i < XPW; i++) begin
            xp[i] = '0;
        end
        for (int i = 0; i < VEC_LEN; i++) begin
            xp[i + PAD] = {{(W_B - W_X){x_q[i][W_X-1]}}, x_q[i]};
        end
    end

    always_comb begin
        base = IW'(cnt_q);
        xc   = xp[base + IW'(PAD)];
        s1   = xp[base + IW'(PAD - 1)] + xp[base + IW'(PAD + 1)];
        s2   = xp[base + IW'(PAD - 2)] + xp[base + IW'(PAD + 2)];
        s3   = xp[base] + xp[base + IW'(PAD + 3)];
        // 20*xc - 13*s1 + 6*s2 - s3
        row_val = (xc <<< 4) + (xc <<< 2)
                - ((s1 <<< 3) + (s1 <<< 2) + s1)
                + (s2 <<< 2) + (s2 <<< 1)
                - s3;
    end

    always_comb begin
        in_ready  = (state_q == S_LOAD);
        out_valid = (state_q == S_OUT);
        overrun   = overrun_q;
        b_out     = out_valid ? b_q[cnt_q] : '0;
        rnd       = {b_out[W_B-1], b_out} + HALF;
        t         = rnd >>> FRAC;
        b_sat     = 1'b0;
        b_int     = t[15:0];
        if (t > T_MAX) begin
            b_int = 16'h7FFF;
            b_sat = 1'b1;
        end else if (t < T_MIN) begin
            b_int = 16'h8000;
            b_sat = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        b_d       = b_q;
        overrun_d = overrun_q | (in_en & ~in_ready);
        case (state_q)
            S_LOAD: begin
                if (in_en) begin
                    x_d[cnt_q] = x_in;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_CALC: begin
                b_d[cnt_q] = row_val;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_OUT: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_LOAD;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < VEC_LEN; i++) begin
                x_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < VEC_LEN; i++) begin
                x_q[i] <= x_d[i];
                b_q[i] <= b_d[i];
            end
        end
    end
endmodule
